// File: rtl/spi_flash_reader.sv
// Serial-flash word reader: turns a byte-address read into the READ byte stream for the SPI master.
// Define SPI_FLASH_FAST_READ_EN to use opcode 0x0B with one dummy byte after the address.
module spi_flash_reader #(
  parameter int          ADDR_WIDTH = 24,
  parameter logic [7:0]  CMD_READ   = 8'h03
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_resp_valid,
  input  logic                  rd_resp_ready,
  output logic [31:0]           rd_resp_data,
  output logic                  busy,
  output logic                  mosi_axis_tvalid,
  input  logic                  mosi_axis_tready,
  output logic [7:0]            mosi_axis_tdata,
  output logic                  mosi_axis_tstrb,
  output logic                  mosi_axis_tlast,
  input  logic                  miso_axis_tvalid,
  output logic                  miso_axis_tready,
  input  logic [7:0]            miso_axis_tdata
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_A2, S_A1, S_A0, S_DUMMY, S_D0, S_D1, S_D2, S_D3, S_WAIT
  } state_e;
`else
  localparam logic [7:0] OPCODE = CMD_READ;
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_A2, S_A1, S_A0, S_D0, S_D1, S_D2, S_D3, S_WAIT
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [1:0]  rx_cnt_q, rx_cnt_d;
  logic [31:0] data_q, data_d;
  logic        resp_vld_q, resp_vld_d;
  logic        rx_done_q, rx_done_d;
  logic        miso_hs, rx_store, rx_last;

  assign rd_req_ready     = aresetn & (state_q == S_IDLE) & ~resp_vld_q;
  assign miso_axis_tready = aresetn & ~resp_vld_q;
  assign rd_resp_valid    = resp_vld_q;
  assign rd_resp_data     = data_q;
  assign busy             = (state_q != S_IDLE) | resp_vld_q;

  // Beats before the data phase carry no flash data and must not consume a lane.
  assign miso_hs  = miso_axis_tvalid & miso_axis_tready;
  assign rx_store = miso_hs & ~(state_q inside {S_IDLE, S_CMD, S_A2, S_A1, S_A0});
  assign rx_last  = rx_store & (rx_cnt_q == 2'd3);

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    rx_cnt_d         = rx_cnt_q;
    data_d           = data_q;
    resp_vld_d       = resp_vld_q;
    rx_done_d        = rx_done_q;
    mosi_axis_tvalid = 1'b0;
    mosi_axis_tdata  = 8'h00;
    mosi_axis_tstrb  = 1'b0;
    mosi_axis_tlast  = 1'b0;

    case (state_q)
      S_IDLE: if (rd_req_valid && rd_req_ready) begin
        addr_d  = 24'(rd_req_addr);
        state_d = S_CMD;
      end
      S_CMD: begin
        mosi_axis_tvalid = 1'b1; mosi_axis_tdata = OPCODE; mosi_axis_tstrb = 1'b1;
        if (mosi_axis_tready) state_d = S_A2;
      end
      S_A2: begin
        mosi_axis_tvalid = 1'b1; mosi_axis_tdata = addr_q[23:16]; mosi_axis_tstrb = 1'b1;
        if (mosi_axis_tready) state_d = S_A1;
      end
      S_A1: begin
        mosi_axis_tvalid = 1'b1; mosi_axis_tdata = addr_q[15:8]; mosi_axis_tstrb = 1'b1;
        if (mosi_axis_tready) state_d = S_A0;
      end
      S_A0: begin
        mosi_axis_tvalid = 1'b1; mosi_axis_tdata = addr_q[7:0]; mosi_axis_tstrb = 1'b1;
`ifdef SPI_FLASH_FAST_READ_EN
        if (mosi_axis_tready) state_d = S_DUMMY;
      end
      S_DUMMY: begin
        mosi_axis_tvalid = 1'b1; mosi_axis_tstrb = 1'b1;
`endif
        if (mosi_axis_tready) state_d = S_D0;
      end
      S_D0: begin
        mosi_axis_tvalid = 1'b1;
        if (mosi_axis_tready) state_d = S_D1;
      end
      S_D1: begin
        mosi_axis_tvalid = 1'b1;
        if (mosi_axis_tready) state_d = S_D2;
      end
      S_D2: begin
        mosi_axis_tvalid = 1'b1;
        if (mosi_axis_tready) state_d = S_D3;
      end
      S_D3: begin
        mosi_axis_tvalid = 1'b1; mosi_axis_tlast = 1'b1;
        if (mosi_axis_tready) state_d = S_WAIT;
      end
      S_WAIT: if (rx_done_q || rx_last) begin
        state_d   = S_IDLE;
        rx_done_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (rx_store) begin
      data_d[{rx_cnt_q, 3'b000} +: 8] = miso_axis_tdata;
      rx_cnt_d = rx_cnt_q + 2'd1;
    end
    // The last byte may land before D3 is acknowledged, so remember it for WAIT.
    if (rx_last) begin
      resp_vld_d = 1'b1;
      if (state_q != S_WAIT) rx_done_d = 1'b1;
    end
    if (resp_vld_q && rd_resp_ready) resp_vld_d = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rx_cnt_q   <= '0;
      data_q     <= '0;
      resp_vld_q <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rx_cnt_q   <= rx_cnt_d;
      data_q     <= data_d;
      resp_vld_q <= resp_vld_d;
      rx_done_q  <= rx_done_d;
    end
  end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Read-request front end that sits directly upstream of the SPI byte-stream master.
- Converts a 32-bit word read at a byte address into the serial-flash READ byte sequence (0x03, 3 address bytes, 4 data bytes) on the master's mosi AXI-Stream.
- Collects the 4 returned bytes from the master's miso stream and returns one little-endian word.
- Used by the boot/XIP path to fetch code and data from SPI NOR flash.

Parameters:
- ADDR_WIDTH, 24: flash byte-address width. Must be ≤ 24; zero-extended to 24 bits on the wire.
- CMD_READ, 8'h03: opcode sent for normal reads.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  read request accepted
- rd_req_addr  in  ADDR_WIDTH  byte address; unaligned allowed
- rd_resp_valid  out  1  read data valid
- rd_resp_ready  in  1  read data consumed
- rd_resp_data  out  32  word; first flash byte in [7:0]
- busy  out  1  transaction in progress, or response pending
- mosi_axis_tvalid  out  1  byte to SPI master valid
- mosi_axis_tready  in  1  one-cycle pulse: byte consumed by master
- mosi_axis_tdata  out  8  byte to shift out
- mosi_axis_tstrb  out  1  1 = discard the byte received in exchange; 0 = return it on miso
- mosi_axis_tlast  out  1  deassert CS after this byte
- miso_axis_tvalid  in  1  returned byte valid
- miso_axis_tready  out  1  returned byte accepted
- miso_axis_tdata  in  8  returned byte

Behaviour:
- Reset (async assert, sync release): all outputs 0; rd_resp_data 0; FSM in IDLE; byte counters 0.
- rd_req_ready = 1 only in IDLE with rd_resp_valid = 0.
- Request handshake (rd_req_valid & rd_req_ready) latches the address, zero-extended to 24 bits, and moves to CMD on the next edge.
- mosi FSM states: IDLE → CMD → A2 → A1 → A0 → [DUMMY] → D0 → D1 → D2 → D3 → WAIT → IDLE.
- In every send state:
  - mosi_axis_tvalid = 1; tdata/tstrb/tlast held stable until the mosi_axis_tready pulse.
  - On the pulse, advance one state on the same edge.
  - tvalid is never deasserted before tready.
- Per-state bytes:
  - CMD: CMD_READ, strb 1.
  - A2/A1/A0: addr[23:16], [15:8], [7:0], strb 1.
  - D0–D2: 8'h00, strb 0, tlast 0.
  - D3: 8'h00, strb 0, tlast 1.
  - tlast is 0 in every other state.
- mosi_axis_tready for D3 arrives only after CS is released.
- D3 ready pulse → WAIT: tvalid 0; hold until all 4 data bytes are collected, then go to IDLE.
- miso side:
  - miso_axis_tready = 1 whenever rd_resp_valid = 0.
  - Each beat stores the byte at lane rx_cnt: byte k → rd_resp_data[8k+7:8k]. rx_cnt (2 bits) then increments.
  - On the 4th beat: rd_resp_valid = 1 next cycle; rx_cnt wraps to 0.
  - Beats arriving in IDLE/CMD/address states are accepted and dropped, and do not increment rx_cnt. Defensive only; not expected with correct strb.
- Response: rd_resp_valid held, with data stable, until rd_resp_ready; clears on that edge.
  - A new request can be accepted on the cycle after the clear, not the same cycle.
- busy = (state != IDLE) | rd_resp_valid.
- Latency: one full transaction per word, no pipelining. Next request's CMD byte is sent only after the previous response is consumed, which guarantees the CS-high gap is enforced downstream.
- Reset mid-transaction: everything aborts immediately; the partial word is discarded. The master shares the reset, so no recovery sequence is needed.
- rd_req_addr changes while not handshaking are ignored.

Optional Feature:
- Macro: SPI_FLASH_FAST_READ_EN.
- Defined:
  - Opcode 8'h0B is used instead of CMD_READ.
  - A DUMMY state follows A0 and sends 8'h00, strb 1, tlast 0.
  - Total 9 bytes per read.
- Undefined: no DUMMY state, opcode CMD_READ, 8 bytes per read; the DUMMY state and its logic are not built.

Test Plan:
- Single read, addr 0x012345, flash model returns AA BB CC DD → mosi bytes 03 01 23 45 00 00 00 00, strb 1 1 1 1 0 0 0 0, tlast only on byte 8; rd_resp_data = 0xDDCCBBAA; busy falls the cycle after the resp handshake.
- Response backpressure: hold rd_resp_ready = 0 for 20 cycles → rd_resp_valid and data stable, rd_req_ready = 0, miso_axis_tready = 0, no new mosi traffic; release → response consumed, next request accepted one cycle later.
- Back-to-back reads at 0x000000 and 0x000004 with rd_req_valid held high → two complete 8-byte sequences, two tlast, responses in order with correct words.
- Stalled master: mosi_axis_tready withheld 15 cycles during A1 → tdata stays 0x23 (addr 0x012345), tvalid stays 1, no state skip.
- aresetn pulsed low during D1 → all outputs 0 asynchronously; a fresh read afterwards returns the correct word with no leftover bytes.
- SPI_FLASH_FAST_READ_EN defined, addr 0xABCDEF → mosi 0B AB CD EF 00 00 00 00 00, strb 1 1 1 1 1 0 0 0 0; data assembled from the last 4 bytes only.
